// File: rtl/iter_shift_pkg.sv
// Shared encodings for the iterative shifter and the ALU decode: op codes,
// FSM states and default widths.
package iter_shift_pkg;

    localparam int WIDTH_DEF   = 32;
    localparam int SHAMT_W_DEF = 5;

    localparam logic [1:0] OP_SLL = 2'b00;
    localparam logic [1:0] OP_SRL = 2'b01;
    localparam logic [1:0] OP_SRA = 2'b10;
    localparam logic [1:0] OP_RSV = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

endpackage : iter_shift_pkg

// File: rtl/shift_step.sv
// Combinational fixed-distance shift stage (STEP positions) built from mux2_1
// cells; SRA fills with the sign bit, SLL/SRL fill with zeros.
module mux2_1 (
    input  logic a,
    input  logic b,
    input  logic sel,
    output logic y
);
    assign y = sel ? b : a;
endmodule : mux2_1

module shift_step
    import iter_shift_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int STEP  = 1
) (
    input  logic [WIDTH-1:0] w,
    input  logic [1:0]       op,
    output logic [WIDTH-1:0] next_w
);
    logic is_left;
    logic fill;

    assign is_left = (op == OP_SLL);
    assign fill    = (op == OP_SRA) & w[WIDTH-1];

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
            logic left_bit;
            logic right_bit;

            if (gi >= STEP) begin : g_left_src
                assign left_bit = w[gi-STEP];
            end else begin : g_left_zero
                assign left_bit = 1'b0;
            end

            if (gi + STEP < WIDTH) begin : g_right_src
                assign right_bit = w[gi+STEP];
            end else begin : g_right_fill
                assign right_bit = fill;
            end

            mux2_1 u_mux (
                .a  (right_bit),
                .b  (left_bit),
                .sel(is_left),
                .y  (next_w[gi])
            );
        end
    endgenerate

endmodule : shift_step

// File: rtl/iter_shift_sequencer.sv
// Multi-cycle SLL/SRL/SRA unit reusing a single shift stage.
// ITER_SHIFT_STEP4_EN adds a 4-position stage used while cnt >= 4.
module iter_shift_sequencer
    import iter_shift_pkg::*;
#(
    parameter int WIDTH   = WIDTH_DEF,
    parameter int SHAMT_W = SHAMT_W_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [1:0]         op,
    input  logic [SHAMT_W-1:0] shamt,
    input  logic [WIDTH-1:0]   data_in,
    output logic               busy,
    output logic               done,
    output logic [WIDTH-1:0]   result
);
    state_t             state_q, state_d;
    logic [SHAMT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0]   work_q, work_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic [1:0]         op_q, op_d;
    logic [WIDTH-1:0]   step1_w;

    shift_step #(.WIDTH(WIDTH), .STEP(1)) u_step1 (
        .w     (work_q),
        .op    (op_q),
        .next_w(step1_w)
    );

`ifdef ITER_SHIFT_STEP4_EN
    logic [WIDTH-1:0] step4_w;

    shift_step #(.WIDTH(WIDTH), .STEP(4)) u_step4 (
        .w     (work_q),
        .op    (op_q),
        .next_w(step4_w)
    );
`endif

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        work_d   = work_q;
        result_d = result_q;
        op_d     = op_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    work_d = data_in;
                    op_d   = op;
                    if (shamt == '0 || op == OP_RSV) begin
                        state_d = S_DONE;
                    end else begin
                        cnt_d   = shamt;
                        state_d = S_SHIFT;
                    end
                end
            end
            S_SHIFT: begin
`ifdef ITER_SHIFT_STEP4_EN
                if (cnt_q >= SHAMT_W'(4)) begin
                    work_d = step4_w;
                    cnt_d  = cnt_q - SHAMT_W'(4);
                end else begin
                    work_d = step1_w;
                    cnt_d  = cnt_q - SHAMT_W'(1);
                end
`else
                work_d = step1_w;
                cnt_d  = cnt_q - SHAMT_W'(1);
`endif
                if (cnt_d == '0) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        // Load the result on the edge entering DONE so it is valid alongside done.
        if (state_d == S_DONE && state_q != S_DONE) begin
            result_d = work_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            work_q   <= '0;
            result_q <= '0;
            op_q     <= OP_SLL;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            work_q   <= work_d;
            result_q <= result_d;
            op_q     <= op_d;
        end
    end

    assign busy   = (state_q != S_IDLE);
    assign done   = (state_q == S_DONE);
    assign result = result_q;

endmodule : iter_shift_sequencer

// File: tb/tb_iter_shift_sequencer.sv
// Scoreboard bench for iter_shift_sequencer: expected result and done timing
// are queued at issue time and compared when done is observed.
module tb_iter_shift_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [4:0]  shamt;
    logic [31:0] data_in;
    logic        busy;
    logic        done;
    logic [31:0] result;

    typedef struct {
        logic [31:0] res;
        int          lat;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    iter_shift_sequencer dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .op     (op),
        .shamt  (shamt),
        .data_in(data_in),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    // Edges after the accepting edge until done becomes visible.
    function automatic int model_lat(input logic [1:0] o, input int s);
        if (s == 0 || o == 2'b11) return 0;
`ifdef ITER_SHIFT_STEP4_EN
        return s / 4 + s % 4;
`else
        return s;
`endif
    endfunction

    function automatic logic [31:0] model_res(input logic [1:0] o, input int s,
                                               input logic [31:0] d);
        logic signed [31:0] sd;
        sd = d;
        case (o)
            2'b00:   return d << s;
            2'b01:   return d >> s;
            2'b10:   return sd >>> s;
            default: return d;
        endcase
    endfunction

    // Drive one start pulse; returns at #1 after the accepting edge.
    task automatic issue(input logic [1:0] o, input int s, input logic [31:0] d,
                         input logic [31:0] exp_res, input bit push);
        exp_t e;
        @(posedge clk);
        #1;
        start   = 1'b1;
        op      = o;
        shamt   = 5'(s);
        data_in = d;
        if (push) begin
            e.res = exp_res;
            e.lat = model_lat(o, s);
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        start   = 1'b0;
        op      = $urandom_range(0, 3);
        shamt   = 5'($urandom);
        data_in = $urandom;
    endtask

    task automatic wait_done(output int cyc);
        cyc = 0;
        while (!done && cyc < 200) begin
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; op = 2'b00; shamt = '0; data_in = '0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0 || result !== 32'h0) begin
            n_fail++;
            $display("FAIL reset: busy=%b done=%b result=%h required 0 0 00000000", busy, done, result);
        end
        rst = 1'b0;
    endtask

    task automatic test_directed();
        logic [1:0]  t_op [6] = '{2'b10, 2'b01, 2'b00, 2'b00, 2'b01, 2'b11};
        int          t_sh [6] = '{4, 4, 31, 0, 0, 7};
        logic [31:0] t_d  [6] = '{32'h8000_0010, 32'h8000_0010, 32'h0000_0001,
                                  32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'h1234_5678};
        logic [31:0] t_r  [6] = '{32'hF800_0001, 32'h0800_0001, 32'h8000_0000,
                                  32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'h1234_5678};
        int   cyc;
        exp_t e;
        for (int i = 0; i < 6; i++) begin
            issue(t_op[i], t_sh[i], t_d[i], t_r[i], 1'b1);
            wait_done(cyc);
            e = sb.pop_front();
            n_checks++;
            if (!done) begin
                n_fail++;
                $display("FAIL directed%0d timeout: done=%b required 1", i, done);
            end else begin
                $display("directed%0d op=%0d shamt=%0d data=%h -> result=%h after %0d cycles",
                         i, t_op[i], t_sh[i], t_d[i], result, cyc);
                if (cyc != e.lat) begin
                    n_fail++;
                    $display("FAIL directed%0d latency: got %0d required %0d", i, cyc, e.lat);
                end
                n_checks++;
                if (result !== e.res) begin
                    n_fail++;
                    $display("FAIL directed%0d result: got %h required %h", i, result, e.res);
                end
            end
            if (e.lat == 0) begin
                @(posedge clk);
                #1;
                n_checks++;
                if (busy !== 1'b0) begin
                    n_fail++;
                    $display("FAIL directed%0d busy_len: busy=%b required 0 one cycle after done", i, busy);
                end
            end
        end
        repeat (5) @(posedge clk);
        #1;
        n_checks++;
        if (result !== 32'h1234_5678 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL result_hold: result=%h done=%b required 12345678 0", result, done);
        end
    endtask

    task automatic test_ignored_start();
        int   dones = 0;
        exp_t e;
        issue(2'b01, 9, 32'hF0F0_1234, model_res(2'b01, 9, 32'hF0F0_1234), 1'b1);
        start = 1'b1; op = 2'b00; shamt = 5'd3; data_in = 32'h0000_00FF;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int c = 0; c < 40; c++) begin
            if (done) begin
                dones++;
                if (dones == 1) begin
                    e = sb.pop_front();
                    $display("ignored_start: result=%h", result);
                    n_checks++;
                    if (result !== e.res) begin
                        n_fail++;
                        $display("FAIL ignored_start result: got %h required %h", result, e.res);
                    end
                end
            end
            @(posedge clk);
            #1;
        end
        n_checks++;
        if (dones != 1) begin
            n_fail++;
            $display("FAIL ignored_start pulses: got %0d required 1", dones);
        end
    endtask

    task automatic test_mid_reset();
        int dones = 0;
        int cyc;
        exp_t e;
        issue(2'b10, 10, 32'h8000_0000, 32'h0, 1'b0);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0 || result !== 32'h0) begin
            n_fail++;
            $display("FAIL mid_reset: busy=%b done=%b result=%h required 0 0 00000000", busy, done, result);
        end
        for (int c = 0; c < 15; c++) begin
            if (done) dones++;
            @(posedge clk);
            #1;
        end
        n_checks++;
        if (dones != 0) begin
            n_fail++;
            $display("FAIL mid_reset stray_done: got %0d pulses required 0", dones);
        end
        issue(2'b10, 5, 32'h8000_0040, 32'hFC00_0002, 1'b1);
        wait_done(cyc);
        e = sb.pop_front();
        n_checks++;
        if (!done || cyc != e.lat || result !== e.res) begin
            n_fail++;
            $display("FAIL post_reset: done=%b cycles=%0d result=%h required 1 %0d %h",
                     done, cyc, result, e.lat, e.res);
        end
    endtask

    task automatic test_back_to_back();
        int          cyc;
        int          s;
        logic [1:0]  o;
        logic [31:0] d;
        exp_t        e;
        for (int i = 0; i < 24; i++) begin
            o = 2'($urandom_range(0, 3));
            s = $urandom_range(0, 31);
            d = $urandom;
            issue(o, s, d, model_res(o, s, d), 1'b1);
            wait_done(cyc);
            e = sb.pop_front();
            $display("b2b%0d op=%0d shamt=%0d data=%h -> result=%h after %0d cycles",
                     i, o, s, d, result, cyc);
            n_checks++;
            if (!done || cyc != e.lat || result !== e.res) begin
                n_fail++;
                $display("FAIL b2b%0d: done=%b cycles=%0d result=%h required 1 %0d %h",
                         i, done, cyc, result, e.lat, e.res);
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_ignored_start();
        test_mid_reset();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_iter_shift_sequencer
